// File: rtl/seg_scan_capture.sv
// Readback receiver for the multiplexed 7-segment scan bus: deglitches each digit dwell,
// decodes glyphs to hex and reassembles 4-digit frames. Define SEG_SYNC_EN to add a 2-flop input synchroniser.
module seg_scan_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  glyph_err,
  output logic        frame_valid,
  output logic [7:0]  frame_count
);

  localparam logic [7:0] STABLE_TC = 8'(STABLE_CYCLES);

  logic [7:0] seg_pre;
  logic [3:0] an_pre;

`ifdef SEG_SYNC_EN
  logic [7:0] seg_s1, seg_s2;
  logic [3:0] an_s1, an_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1 <= 8'h00;
      seg_s2 <= 8'h00;
      an_s1  <= 4'h0;
      an_s2  <= 4'h0;
    end else begin
      seg_s1 <= seg_in;
      seg_s2 <= seg_s1;
      an_s1  <= an_in;
      an_s2  <= an_s1;
    end
  end

  assign seg_pre = seg_s2;
  assign an_pre  = an_s2;
`else
  assign seg_pre = seg_in;
  assign an_pre  = an_in;
`endif

  logic [7:0]  seg_q;
  logic [3:0]  an_q;
  logic [11:0] prev_pair;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;
  logic [11:0] cur_pair;

  assign seg_n    = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign an_n     = AN_ACTIVE_LOW  ? ~an_q  : an_q;
  assign cur_pair = {an_n, seg_n};

  logic       an_valid;
  logic [1:0] an_idx;

  always_comb begin
    an_valid = 1'b0;
    an_idx   = 2'd0;
    case (an_n)
      4'b0001: begin an_valid = 1'b1; an_idx = 2'd0; end
      4'b0010: begin an_valid = 1'b1; an_idx = 2'd1; end
      4'b0100: begin an_valid = 1'b1; an_idx = 2'd2; end
      4'b1000: begin an_valid = 1'b1; an_idx = 2'd3; end
      default: begin an_valid = 1'b0; an_idx = 2'd0; end
    endcase
  end

  // Returns {err, nibble}; unknown patterns decode to nibble 0 with err set.
  function automatic logic [4:0] decode_glyph(input logic [6:0] s);
    case (s)
      7'h3F:   return 5'h00;
      7'h06:   return 5'h01;
      7'h5B:   return 5'h02;
      7'h4F:   return 5'h03;
      7'h66:   return 5'h04;
      7'h6D:   return 5'h05;
      7'h7D:   return 5'h06;
      7'h07:   return 5'h07;
      7'h7F:   return 5'h08;
      7'h6F:   return 5'h09;
      7'h77:   return 5'h0A;
      7'h7C:   return 5'h0B;
      7'h39:   return 5'h0C;
      7'h5E:   return 5'h0D;
      7'h79:   return 5'h0E;
      7'h71:   return 5'h0F;
      default: return 5'h10;
    endcase
  endfunction

  logic [4:0] glyph;
  assign glyph = decode_glyph(seg_n[6:0]);

  logic [7:0] cnt, cnt_nxt;
  logic       captured, captured_nxt;
  logic       capture;

  // The captured flag limits each dwell to a single capture while the count sits saturated.
  always_comb begin
    cnt_nxt      = cnt;
    captured_nxt = captured;
    capture      = 1'b0;
    if (!an_valid) begin
      cnt_nxt      = 8'd0;
      captured_nxt = 1'b0;
    end else if (cur_pair != prev_pair) begin
      cnt_nxt      = 8'd1;
      captured_nxt = 1'b0;
    end else begin
      if (cnt < STABLE_TC)
        cnt_nxt = cnt + 8'd1;
      if (!captured && (cnt_nxt == STABLE_TC)) begin
        capture      = 1'b1;
        captured_nxt = 1'b1;
      end
    end
  end

  logic [3:0]  seen, seen_nxt;
  logic        frame_done;
  logic [15:0] sh_dig;
  logic [3:0]  sh_dp, sh_err;

  assign frame_done = &seen;

  // A capture landing on the completion edge belongs to the next frame.
  always_comb begin
    seen_nxt = frame_done ? 4'h0 : seen;
    if (capture)
      seen_nxt[an_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q       <= 8'h00;
      an_q        <= 4'h0;
      prev_pair   <= 12'h000;
      cnt         <= 8'd0;
      captured    <= 1'b0;
      seen        <= 4'h0;
      sh_dig      <= 16'h0000;
      sh_dp       <= 4'h0;
      sh_err      <= 4'h0;
      digits      <= 16'h0000;
      dp          <= 4'h0;
      glyph_err   <= 4'h0;
      frame_valid <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      seg_q       <= seg_pre;
      an_q        <= an_pre;
      prev_pair   <= cur_pair;
      cnt         <= cnt_nxt;
      captured    <= captured_nxt;
      seen        <= seen_nxt;
      frame_valid <= frame_done;
      if (capture) begin
        sh_dig[{an_idx, 2'b00} +: 4] <= glyph[3:0];
        sh_dp[an_idx]                <= seg_n[7];
        sh_err[an_idx]               <= glyph[4];
      end
      if (frame_done) begin
        digits      <= sh_dig;
        dp          <= sh_dp;
        glyph_err   <= sh_err;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: dwell-level reference model predicts each frame
// (completion edge, digits, dp, glyph_err, count) and is compared with pulses observed on the DUT.
module tb_seg_scan_capture;

  localparam int STABLE = 4;
`ifdef SEG_SYNC_EN
  localparam int LAT = STABLE + 3;
`else
  localparam int LAT = STABLE + 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  seg_in = 8'hFF;
  logic [3:0]  an_in = 4'hF;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  glyph_err;
  logic        frame_valid;
  logic [7:0]  frame_count;

  seg_scan_capture #(.STABLE_CYCLES(STABLE), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
    .digits(digits), .dp(dp), .glyph_err(glyph_err),
    .frame_valid(frame_valid), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct packed {
    logic [31:0] e;
    logic [15:0] d;
    logic [3:0]  p;
    logic [3:0]  g;
    logic [7:0]  c;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  logic [3:0] m_nib [4];
  logic [3:0] m_dp, m_err, m_seen;
  logic [7:0] m_cnt;

  function automatic logic [4:0] glyph_val(input logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (glyph_tab[i] == s) return {1'b0, 4'(i)};
    return 5'h10;
  endfunction

  task automatic cycle(input logic [3:0] an, input logic [7:0] seg, input logic r);
    ev_t ev;
    an_in = an;
    seg_in = seg;
    rst = r;
    @(posedge clk);
    edge_n++;
    #1;
    if (frame_valid === 1'b1) begin
      ev.e = 32'(edge_n);
      ev.d = digits;
      ev.p = dp;
      ev.g = glyph_err;
      ev.c = frame_count;
      obs_q.push_back(ev);
    end
  endtask

  // One dwell of a constant pair; sel and segs are active-high, driven active-low on the pins.
  task automatic dwell(input logic [3:0] sel, input logic [6:0] segs, input logic dpv, input int len);
    int t;
    int idx;
    logic [4:0] gv;
    ev_t ev;
    t = edge_n + 1;
    if ($countones(sel) == 1 && len >= STABLE) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
      gv = glyph_val(segs);
      m_nib[idx] = gv[3:0];
      m_err[idx] = gv[4];
      m_dp[idx] = dpv;
      m_seen[idx] = 1'b1;
      if (m_seen == 4'hF) begin
        m_seen = 4'h0;
        m_cnt = m_cnt + 8'd1;
        ev.e = 32'(t + LAT);
        ev.d = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
        ev.p = m_dp;
        ev.g = m_err;
        ev.c = m_cnt;
        exp_q.push_back(ev);
      end
    end
    repeat (len) cycle(~sel, ~{dpv, segs}, 1'b0);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
    m_dp = 4'h0;
    m_err = 4'h0;
    m_seen = 4'h0;
    m_cnt = 8'd0;
  endtask

  task automatic do_reset();
    exp_q.delete();
    obs_q.delete();
    cycle(4'hF, 8'hFF, 1'b1);
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({digits, dp, glyph_err, frame_valid, frame_count} !== 37'd0) begin
      failures++;
      $display("FAIL reset_init got=%h exp=0", {digits, dp, glyph_err, frame_valid, frame_count});
    end
    dwell(4'b0001, glyph_tab[9], 1'b1, 6);
    dwell(4'b0010, glyph_tab[8], 1'b0, 6);
    dwell(4'b0100, glyph_tab[7], 1'b0, 6);
    dwell(4'b1000, glyph_tab[6], 1'b1, 6);
    dwell(4'b0001, glyph_tab[1], 1'b0, 8);
    dwell(4'b0010, glyph_tab[2], 1'b0, 8);
    cycle(4'hF, 8'hFF, 1'b1);
    model_clear();
    checks++;
    if ({digits, dp, glyph_err, frame_valid, frame_count} !== 37'd0) begin
      failures++;
      $display("FAIL reset_mid got=%h exp=0", {digits, dp, glyph_err, frame_valid, frame_count});
    end
    dwell(4'b0100, glyph_tab[3], 1'b0, 8);
    dwell(4'b1000, glyph_tab[4], 1'b0, 8);
    dwell(4'b0000, 7'h00, 1'b0, 8);
    checks++;
    if (digits !== 16'h0 || frame_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_partial got=%h/%0d exp=0/0", digits, frame_count);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL reset_events got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL reset_ev%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_scan();
    int t7;
    do_reset();
    dwell(4'b0001, glyph_tab[4], 1'b0, 8);
    dwell(4'b0010, glyph_tab[3], 1'b0, 8);
    dwell(4'b0100, glyph_tab[2], 1'b0, 8);
    t7 = edge_n + 1;
    dwell(4'b1000, glyph_tab[1], 1'b0, 8);
    dwell(4'b0000, 7'h00, 1'b0, 6);
    checks++;
    if (obs_q.size() != 1) begin
      failures++;
      $display("FAIL scan_pulses got=%0d exp=1", obs_q.size());
    end
    if (obs_q.size() > 0) begin
      checks++;
      if (obs_q[0].d !== 16'h1234 || obs_q[0].g !== 4'h0 || obs_q[0].c !== 8'd1) begin
        failures++;
        $display("FAIL scan_value got=%h/%h/%0d exp=1234/0/1", obs_q[0].d, obs_q[0].g, obs_q[0].c);
      end
      checks++;
`ifdef SEG_SYNC_EN
      if (obs_q[0].e !== 32'(t7 + 7)) begin
`else
      if (obs_q[0].e !== 32'(t7 + 5)) begin
`endif
        failures++;
        $display("FAIL scan_latency got_edge=%0d first_edge=%0d", obs_q[0].e, t7);
      end
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL scan_ev%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_short_dwell();
    do_reset();
    dwell(4'b0001, glyph_tab[5], 1'b0, 8);
    dwell(4'b0010, glyph_tab[6], 1'b0, 8);
    dwell(4'b0100, glyph_tab[7], 1'b0, 3);
    dwell(4'b1000, glyph_tab[8], 1'b0, 8);
    dwell(4'b0000, 7'h00, 1'b0, 6);
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL short_nopulse got=%0d exp=0", obs_q.size());
    end
    dwell(4'b0100, glyph_tab[7], 1'b0, 4);
    dwell(4'b0000, 7'h00, 1'b0, 6);
    checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 1) begin
      failures++;
      $display("FAIL short_events got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL short_ev%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_blanking();
    do_reset();
    dwell(4'b0001, glyph_tab[10], 1'b0, 8);
    dwell(4'b0010, glyph_tab[11], 1'b0, 8);
    dwell(4'b0100, glyph_tab[12], 1'b0, 8);
    dwell(4'b1100, glyph_tab[13], 1'b0, 20);
    dwell(4'b0000, 7'h00, 1'b0, 4);
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL blank_nopulse got=%0d exp=0", obs_q.size());
    end
    dwell(4'b1000, glyph_tab[14], 1'b0, 8);
    dwell(4'b0000, 7'h00, 1'b0, 6);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL blank_events got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL blank_ev%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_glyph_err();
    do_reset();
    dwell(4'b0001, glyph_tab[5], 1'b1, 8);
    dwell(4'b0010, glyph_tab[7], 1'b0, 8);
    dwell(4'b0100, 7'h49, 1'b0, 8);
    dwell(4'b1000, glyph_tab[10], 1'b0, 8);
    dwell(4'b0000, 7'h00, 1'b0, 6);
    checks++;
    if (obs_q.size() != 1) begin
      failures++;
      $display("FAIL err_pulses got=%0d exp=1", obs_q.size());
    end
    if (obs_q.size() > 0) begin
      checks++;
      if (obs_q[0].d[11:8] !== 4'h0 || obs_q[0].g !== 4'b0100 || obs_q[0].p !== 4'b0001) begin
        failures++;
        $display("FAIL err_value got=%h/%b/%b exp=0/0100/0001", obs_q[0].d[11:8], obs_q[0].g, obs_q[0].p);
      end
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL err_ev%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int f = 0; f < 256; f++)
      for (int d = 0; d < 4; d++)
        dwell(4'b0001 << d, glyph_tab[$urandom_range(0, 15)], 1'($urandom_range(0, 1)),
              $urandom_range(4, 6));
    dwell(4'b0000, 7'h00, 1'b0, 6);
    checks++;
    if (frame_count !== 8'd0 || obs_q.size() != 256) begin
      failures++;
      $display("FAIL wrap_count got=%0d/%0d exp=0/256", frame_count, obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL wrap_ev%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] sel, last_sel;
    logic [6:0] segs, last_segs;
    logic       dpv, last_dp;
    do_reset();
    last_sel = 4'h0;
    last_segs = 7'h00;
    last_dp = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) != 0) sel = 4'b0001 << $urandom_range(0, 3);
      else sel = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) segs = 7'($urandom);
      else segs = glyph_tab[$urandom_range(0, 15)];
      dpv = 1'($urandom_range(0, 1));
      if (sel == last_sel && segs == last_segs && dpv == last_dp) segs = segs ^ 7'h01;
      dwell(sel, segs, dpv, $urandom_range(1, 8));
      last_sel = sel;
      last_segs = segs;
      last_dp = dpv;
    end
    dwell(4'b0000, 7'h00, 1'b0, 6);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rand_events got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rand_ev%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_scan();
    test_short_dwell();
    test_blanking();
    test_glyph_err();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
